// File: rtl/meta_array.sv
// rtl/meta_array.sv - resettable, flushable cache metadata array with masked writes
// Registered read port, independent write port, read-during-write forwarding, flush sequencer.
module meta_array #(
    parameter int                 s_index    = 3,
    parameter int                 width      = 1,
    parameter logic [width-1:0]   INIT_VALUE = {width{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic               load,
    input  logic [s_index-1:0] rindex,
    input  logic [s_index-1:0] windex,
    input  logic [width-1:0]   datain,
    input  logic [width-1:0]   wmask,
    input  logic               flush,
    output logic               busy,
    output logic [width-1:0]   dataout
);

    localparam int num_sets = 2 ** s_index;
    localparam logic [s_index-1:0] LAST_SET = s_index'(num_sets - 1);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [s_index-1:0] r_count;
    logic [width-1:0]   r_data [num_sets];
    logic [width-1:0]   r_dataout;
    logic [width-1:0]   w_merged;
    logic               w_idle;
    logic               w_last;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_last   = (r_count == LAST_SET);
    assign w_merged = (r_data[windex] & ~wmask) | (datain & wmask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (flush)  w_next_state = ST_FLUSH;
            ST_FLUSH: if (w_last) w_next_state = ST_IDLE;
            default:              w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == ST_FLUSH);
        dataout = r_dataout;
    end

    // The counter is cleared on exit so the walk ends after exactly one pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_idle) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // A load in the flush-request cycle lands first; the walk overwrites it later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < num_sets; i++) begin
                r_data[i] <= INIT_VALUE;
            end
        end else if (!w_idle) begin
            r_data[r_count] <= INIT_VALUE;
        end else if (load) begin
            r_data[windex] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataout <= INIT_VALUE;
        end else if (w_idle && read) begin
            if (load && (rindex == windex)) begin
                r_dataout <= w_merged;
            end else begin
                r_dataout <= r_data[rindex];
            end
        end
    end

endmodule
